vote_counter: RTL and testbench
===============================

VOTE_COUNTER -- requirements
Module: vote_counter

Interface
REQ-001 The module SHALL have parameter CNT_W, default 6, giving the per-candidate count width; it matches the VA..VD width of the winner-decision stage.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The module SHALL have port open_i, input, 1 bit, a one-cycle pulse that starts an election.
REQ-005 The module SHALL have port close_i, input, 1 bit, a one-cycle pulse that ends an election.
REQ-006 The module SHALL have port vote_valid, input, 1 bit, meaning a vote is offered.
REQ-007 The module SHALL have port vote_id, input, 2 bits, the candidate ID: 00=A, 01=B, 10=C, 11=D.
REQ-008 The module SHALL have port vote_ready, output, 1 bit, meaning a vote can be accepted this cycle.
REQ-009 The module SHALL have ports VA, VB, VC and VD, outputs, CNT_W bits each, the per-candidate counts fed downstream.
REQ-010 The module SHALL have port total, output, CNT_W+2 bits, the sum of accepted votes.
REQ-011 The module SHALL have port results_valid, output, 1 bit, meaning counts are final.
REQ-012 The module SHALL have port ovf, output, 1 bit, the sticky saturation flag.

Function
REQ-013 The FSM SHALL have the states IDLE, OPEN and CLOSED.
REQ-014 From IDLE, open_i SHALL move the FSM to OPEN; close_i in IDLE SHALL be ignored.
REQ-015 From OPEN, close_i SHALL move the FSM to CLOSED; open_i in OPEN SHALL be ignored.
REQ-016 From CLOSED, open_i SHALL move the FSM to OPEN; close_i in CLOSED SHALL be ignored.
REQ-017 On every transition into OPEN, VA..VD, total and ovf SHALL be cleared to 0 on the same edge.
REQ-018 vote_ready SHALL be 1 only in state OPEN and SHALL be a function of the registered state only.
REQ-019 A vote SHALL be accepted when vote_valid and vote_ready are both 1 at a rising edge.
REQ-020 An accepted vote SHALL increment the count selected by vote_id, and total, on that same edge; the new value is visible the next cycle (latency 1).
REQ-021 A vote offered when vote_ready is 0 SHALL be dropped, with no counter change.
REQ-022 A count at 2^CNT_W-1 SHALL saturate: it holds its value, total is not incremented, and ovf is set (only when VOTE_OVF_FLAG_EN is defined).
REQ-023 When a vote and close_i occur on the same edge in OPEN, the vote SHALL be counted and the FSM SHALL enter CLOSED.
REQ-024 When open_i and close_i are both high, open_i SHALL take priority in IDLE and CLOSED, and close_i SHALL take priority in OPEN.
REQ-025 results_valid SHALL be 1 exactly while the state is CLOSED.
REQ-026 VA..VD and total SHALL hold their final values in CLOSED until the next open_i.
REQ-027 total SHALL always equal VA+VB+VC+VD.

Reset
REQ-028 While rst_n is 0, the FSM SHALL be in IDLE, and VA..VD, total, ovf, vote_ready and results_valid SHALL all be 0.
REQ-029 A reset asserted mid-election SHALL abort it and discard all counts.
REQ-030 Votes SHALL be ignored until open_i is seen after rst_n is released.

Configuration
REQ-031 With VOTE_OVF_FLAG_EN defined, ovf SHALL be set on the first vote rejected by saturation and SHALL hold until the next entry into OPEN or reset.
REQ-032 Without VOTE_OVF_FLAG_EN, ovf SHALL be tied to 0 and no flag register SHALL exist; saturation behaviour SHALL be unchanged.

Structure
REQ-033 The package vote_pkg SHALL hold: the state enum (IDLE, OPEN, CLOSED), the candidate ID constants CAND_A..CAND_D, and the default CNT_W.
REQ-034 A sub-module cand_counter SHALL implement one saturating counter (inputs clr, inc; outputs cnt, sat) and SHALL be instantiated four times.

Verification
REQ-035 Reset, open_i, then 17 votes A, 15 B, 15 C, 53 D, then close_i -> VA=17, VB=15, VC=15, VD=53 (010001/001111/001111/110101), total=100, results_valid=1.
REQ-036 Votes offered in IDLE and in CLOSED -> vote_ready=0 and all counts unchanged.
REQ-037 70 votes for B in OPEN -> VB=63, total=63, ovf=1 with the macro and ovf=0 without it.
REQ-038 Vote C coincident with close_i -> VC increments by 1 and the next cycle shows results_valid=1.
REQ-039 rst_n pulsed low mid-election with VA=5 -> all outputs 0 immediately (asynchronous), state IDLE.
REQ-040 open_i issued in CLOSED with VD=9 -> VD=0 and vote_ready=1 the next cycle.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the four-candidate vote counter:
// FSM state encoding, candidate IDs and the default count width.
package vote_pkg;

    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        CLOSED = 2'd2
    } state_e;

    localparam logic [1:0] CAND_A = 2'd0;
    localparam logic [1:0] CAND_B = 2'd1;
    localparam logic [1:0] CAND_C = 2'd2;
    localparam logic [1:0] CAND_D = 2'd3;

endpackage

// File: rtl/cand_counter.sv
// One saturating per-candidate tally; sat flags that the next increment
// would wrap, so the caller can refuse it and keep the total consistent.
module cand_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat = (cnt_q == {W{1'b1}});
    assign cnt = cnt_q;

endmodule

// File: rtl/vote_counter.sv
// Four-candidate election counter with IDLE/OPEN/CLOSED control FSM.
// Build option: define VOTE_OVF_FLAG_EN to get a sticky saturation flag on ovf.
module vote_counter
    import vote_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open_i,
    input  logic             close_i,
    input  logic             vote_valid,
    input  logic [1:0]       vote_id,
    output logic             vote_ready,
    output logic [CNT_W-1:0] VA,
    output logic [CNT_W-1:0] VB,
    output logic [CNT_W-1:0] VC,
    output logic [CNT_W-1:0] VD,
    output logic [CNT_W+1:0] total,
    output logic             results_valid,
    output logic             ovf
);

    state_e           state_q, state_d;
    logic             clr;
    logic             accept;
    logic [3:0]       sat;
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W+1:0] total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In OPEN close wins over open; elsewhere open wins and close is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (open_i)  state_d = OPEN;
            OPEN:    if (close_i) state_d = CLOSED;
            CLOSED:  if (open_i)  state_d = OPEN;
            default: state_d = IDLE;
        endcase
    end

    assign clr           = (state_q != OPEN) && open_i;
    assign accept        = vote_valid && vote_ready;
    assign vote_ready    = (state_q == OPEN);
    assign results_valid = (state_q == CLOSED);

    for (genvar i = 0; i < 4; i++) begin : g_cand
        cand_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (accept && (vote_id == 2'(i))),
            .cnt   (cnt[i]),
            .sat   (sat[i])
        );
    end

    // Total only follows votes that actually landed, so it always equals the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (clr) begin
            total_q <= '0;
        end else if (accept && !sat[vote_id]) begin
            total_q <= total_q + 1'b1;
        end
    end

`ifdef VOTE_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (accept && sat[vote_id]) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign VA    = cnt[0];
    assign VB    = cnt[1];
    assign VC    = cnt[2];
    assign VD    = cnt[3];
    assign total = total_q;

endmodule

// File: tb/tb_vote_counter.sv
// Directed bench for vote_counter: a reference model pushes expected outputs
// into a scoreboard queue after each edge, and checkOutput pops and compares.
module tb_vote_counter;
    import vote_pkg::*;

    typedef struct {
        logic [5:0] va, vb, vc, vd;
        logic [7:0] total;
        logic       ready, rv, ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       openI = 1'b0, closeI = 1'b0, voteValid = 1'b0;
    logic [1:0] voteId = 2'd0;
    logic       voteReady, resultsValid, ovfO;
    logic [5:0] va, vb, vc, vd;
    logic [7:0] total;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sbQ[$];
    int   mState = 0;
    int   mCnt[4] = '{0, 0, 0, 0};
    logic mOvf = 1'b0;

    vote_counter #(.CNT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .open_i        (openI),
        .close_i       (closeI),
        .vote_valid    (voteValid),
        .vote_id       (voteId),
        .vote_ready    (voteReady),
        .VA            (va),
        .VB            (vb),
        .VC            (vc),
        .VD            (vd),
        .total         (total),
        .results_valid (resultsValid),
        .ovf           (ovfO)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t snapshot();
        exp_t e;
        e.va    = 6'(mCnt[0]);
        e.vb    = 6'(mCnt[1]);
        e.vc    = 6'(mCnt[2]);
        e.vd    = 6'(mCnt[3]);
        e.total = 8'(mCnt[0] + mCnt[1] + mCnt[2] + mCnt[3]);
        e.ready = (mState == 1);
        e.rv    = (mState == 2);
        e.ovf   = mOvf;
        return e;
    endfunction

    task automatic modelReset();
        mState = 0;
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
        mOvf = 1'b0;
    endtask

    // Reference behaviour at one rising edge, using pre-edge state and inputs.
    task automatic modelEdge(input logic op, input logic cl, input logic vv, input logic [1:0] id);
        case (mState)
            0, 2: begin
                if (op) begin
                    modelReset();
                    mState = 1;
                end
            end
            1: begin
                if (vv) begin
                    if (mCnt[id] < 63) begin
                        mCnt[id] = mCnt[id] + 1;
                    end else begin
`ifdef VOTE_OVF_FLAG_EN
                        mOvf = 1'b1;
`endif
                    end
                end
                if (cl) mState = 2;
            end
            default: mState = 0;
        endcase
    endtask

    task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string step);
        exp_t e;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s/scoreboard: observed empty queue expected entry", step);
            return;
        end
        e = sbQ.pop_front();
        checkField({step, "/VA"}, {2'b0, va}, {2'b0, e.va});
        checkField({step, "/VB"}, {2'b0, vb}, {2'b0, e.vb});
        checkField({step, "/VC"}, {2'b0, vc}, {2'b0, e.vc});
        checkField({step, "/VD"}, {2'b0, vd}, {2'b0, e.vd});
        checkField({step, "/total"}, total, e.total);
        checkField({step, "/vote_ready"}, {7'b0, voteReady}, {7'b0, e.ready});
        checkField({step, "/results_valid"}, {7'b0, resultsValid}, {7'b0, e.rv});
        checkField({step, "/ovf"}, {7'b0, ovfO}, {7'b0, e.ovf});
    endtask

    task automatic applyStimulus(input logic op, input logic cl, input logic vv, input logic [1:0] id);
        openI = op;
        closeI = cl;
        voteValid = vv;
        voteId = id;
        @(posedge clk);
        modelEdge(op, cl, vv, id);
        #1;
        openI = 1'b0;
        closeI = 1'b0;
        voteValid = 1'b0;
        sbQ.push_back(snapshot());
    endtask

    task automatic step(input logic op, input logic cl, input logic vv, input logic [1:0] id, input string tag);
        applyStimulus(op, cl, vv, id);
        checkOutput(tag);
    endtask

    initial begin
        // Reset state, then release and show IDLE ignores votes and close.
        #1;
        modelReset();
        sbQ.push_back(snapshot());
        checkOutput("reset");
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, CAND_B, "idleVote");
        step(1'b0, 1'b1, 1'b1, CAND_A, "idleClose");

        // Main tally: 17 A, 15 B, 15 C, 53 D.
        step(1'b1, 1'b0, 1'b0, CAND_A, "open1");
        for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b1, CAND_A, "voteA");
        for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 1'b1, CAND_B, "voteB");
        for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 1'b1, CAND_C, "voteC");
        for (int k = 0; k < 53; k++) step(1'b0, 1'b0, 1'b1, CAND_D, "voteD");
        step(1'b0, 1'b1, 1'b0, CAND_A, "close1");
        checkField("tally/VA", {2'b0, va}, 8'd17);
        checkField("tally/VD", {2'b0, vd}, 8'd53);
        checkField("tally/total", total, 8'd100);

        // Votes and close in CLOSED are ignored.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, CAND_C, "closedVote");
        step(1'b0, 1'b1, 1'b0, CAND_A, "closedClose");

        // Re-open from CLOSED with open and close together: open wins, counts clear.
        step(1'b1, 1'b1, 1'b0, CAND_A, "reopenBoth");
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b1, CAND_D, "voteD9");
        step(1'b0, 1'b1, 1'b0, CAND_A, "close2");
        step(1'b1, 1'b0, 1'b0, CAND_A, "reopenVD9");
        checkField("reopen/VD", {2'b0, vd}, 8'd0);

        // Saturation: 70 votes for B, plus open ignored while OPEN.
        step(1'b1, 1'b0, 1'b1, CAND_B, "openInOpen");
        for (int k = 0; k < 69; k++) step(1'b0, 1'b0, 1'b1, CAND_B, "satB");
        checkField("sat/VB", {2'b0, vb}, 8'd63);
        checkField("sat/total", total, 8'd63);

        // Open and close together in OPEN: close wins.
        step(1'b1, 1'b1, 1'b1, CAND_A, "bothInOpen");

        // Vote C coincident with close.
        step(1'b1, 1'b0, 1'b0, CAND_A, "open3");
        step(1'b0, 1'b0, 1'b1, CAND_C, "voteC1");
        step(1'b0, 1'b0, 1'b1, CAND_C, "voteC2");
        step(1'b0, 1'b1, 1'b1, CAND_C, "voteCClose");
        checkField("coincident/VC", {2'b0, vc}, 8'd3);

        // Asynchronous reset mid-election with VA=5.
        step(1'b1, 1'b0, 1'b0, CAND_A, "open4");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, CAND_A, "voteA5");
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        sbQ.push_back(snapshot());
        checkOutput("asyncReset");
        #1;
        rstN = 1'b1;
        step(1'b0, 1'b0, 1'b1, CAND_A, "postResetVote");
        step(1'b1, 1'b0, 1'b1, CAND_A, "open5");
        step(1'b0, 1'b0, 1'b1, CAND_A, "voteAfterOpen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
